// File: rtl/punc_control_pkg.sv
// Shared control/datapath definitions for the PUNC core.
// Opcodes, controller states, ALU and mux select encodings.
package punc_control_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXEC2,
        S_CCUPD,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_NOT  = 2'd3;

    localparam logic [2:0] MRA_PC    = 3'd0;
    localparam logic [2:0] MRA_PCSX  = 3'd1;
    localparam logic [2:0] MRA_IND   = 3'd2;
    localparam logic [2:0] MRA_MDATA = 3'd3;
    localparam logic [2:0] MRA_ALU   = 3'd4;

    localparam logic [1:0] WDS_ALU  = 2'd0;
    localparam logic [1:0] WDS_PC   = 2'd1;
    localparam logic [1:0] WDS_MEM  = 2'd2;
    localparam logic [1:0] WDS_PCSX = 2'd3;

    localparam logic [3:0] SX_NONE  = 4'b0000;
    localparam logic [3:0] SX_IMM5  = 4'b1000;
    localparam logic [3:0] SX_OFF6  = 4'b0100;
    localparam logic [3:0] SX_OFF9  = 4'b0010;
    localparam logic [3:0] SX_OFF11 = 4'b0001;

endpackage

// File: rtl/punc_control.sv
// PUNC controller: state register plus next-state/output decode.
// In: clk, rst, ir. Out: PC/IR/memory/RF/ALU controls, NZP mask, halted.
module punc_control
    import punc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    output logic        ir_ld,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        pc_ld,
    output logic        JMP_RET_JSRR,
    output logic [2:0]  mem_r_addr_sel,
    output logic        mem_wr_en,
    output logic        state2_STI,
    output logic        STR,
    output logic [2:0]  RF_r_addr_0,
    output logic [2:0]  RF_r_addr_1,
    output logic [2:0]  RF_wr_addr,
    output logic        RF_wr_en,
    output logic [1:0]  RF_w_data_sel,
    output logic [1:0]  alu_sel,
    output logic        add_const,
    output logic        cc_en,
    output logic        n,
    output logic        z,
    output logic        p,
    output logic [10:0] const_n,
    output logic [3:0]  SEXT_Select,
    output logic        halted
);

    state_t     r_state;
    state_t     w_next;
    state_t     w_state;
    logic [3:0] w_op;
    logic [2:0] w_dr;
    logic [2:0] w_sr;

    assign w_op    = ir[15:12];
    assign w_dr    = ir[11:9];
    assign w_sr    = ir[8:6];
    assign const_n = ir[10:0];

    // Reset overrides the decode so no write can
    // escape in the cycle reset is raised.
    assign w_state = rst ? S_INIT : r_state;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        ir_ld          = 1'b0;
        pc_clr         = 1'b0;
        pc_up          = 1'b0;
        pc_ld          = 1'b0;
        JMP_RET_JSRR   = 1'b0;
        mem_r_addr_sel = MRA_PC;
        mem_wr_en      = 1'b0;
        state2_STI     = 1'b0;
        STR            = 1'b0;
        RF_r_addr_0    = 3'd0;
        RF_r_addr_1    = 3'd0;
        RF_wr_addr     = 3'd0;
        RF_wr_en       = 1'b0;
        RF_w_data_sel  = WDS_ALU;
        alu_sel        = ALU_PASS;
        add_const      = 1'b0;
        cc_en          = 1'b0;
        n              = 1'b0;
        z              = 1'b0;
        p              = 1'b0;
        SEXT_Select    = SX_NONE;
        halted         = 1'b0;

        unique case (w_state)
            S_INIT: begin
                pc_clr = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_r_addr_sel = MRA_PC;
                ir_ld          = 1'b1;
                pc_up          = 1'b1;
                w_next         = S_DECODE;
            end
            S_DECODE: begin
                w_next = (w_op == OP_TRAP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        RF_r_addr_0 = w_sr;
                        RF_r_addr_1 = ir[2:0];
                        add_const   = ir[5];
                        SEXT_Select = SX_IMM5;
                        alu_sel     = (w_op == OP_ADD) ? ALU_ADD :
                                      (w_op == OP_AND) ? ALU_AND :
                                                         ALU_NOT;
                        RF_wr_addr  = w_dr;
                        RF_wr_en    = 1'b1;
                        cc_en       = 1'b1;
                    end
                    OP_BR: begin
                        n           = ir[11];
                        z           = ir[10];
                        p           = ir[9];
                        SEXT_Select = SX_OFF9;
                    end
                    OP_JMP: begin
                        RF_r_addr_0  = w_sr;
                        JMP_RET_JSRR = 1'b1;
                        pc_ld        = 1'b1;
                    end
                    OP_JSR: begin
                        RF_wr_addr    = 3'd7;
                        RF_w_data_sel = WDS_PC;
                        RF_wr_en      = 1'b1;
                        pc_ld         = 1'b1;
                        if (ir[11]) begin
                            SEXT_Select = SX_OFF11;
                        end else begin
                            RF_r_addr_0  = w_sr;
                            JMP_RET_JSRR = 1'b1;
                        end
                    end
                    OP_LD, OP_LDR, OP_LEA: begin
                        RF_wr_addr = w_dr;
                        RF_wr_en   = 1'b1;
                        w_next     = S_CCUPD;
                        if (w_op == OP_LD) begin
                            RF_w_data_sel  = WDS_MEM;
                            mem_r_addr_sel = MRA_PCSX;
                            SEXT_Select    = SX_OFF9;
                        end else if (w_op == OP_LDR) begin
                            RF_w_data_sel  = WDS_MEM;
                            mem_r_addr_sel = MRA_ALU;
                            RF_r_addr_0    = w_sr;
                            alu_sel        = ALU_ADD;
                            add_const      = 1'b1;
                            SEXT_Select    = SX_OFF6;
                        end else begin
                            RF_w_data_sel = WDS_PCSX;
                            SEXT_Select   = SX_OFF9;
                        end
                    end
                    OP_LDI, OP_STI: begin
                        // First hop: fetch the pointer into the
                        // datapath's indirect latch.
                        mem_r_addr_sel = MRA_PCSX;
                        SEXT_Select    = SX_OFF9;
                        w_next         = S_EXEC2;
                    end
                    OP_ST: begin
                        RF_r_addr_0 = w_dr;
                        SEXT_Select = SX_OFF9;
                        mem_wr_en   = 1'b1;
                    end
                    OP_STR: begin
                        STR         = 1'b1;
                        RF_r_addr_0 = w_sr;
                        RF_r_addr_1 = w_dr;
                        alu_sel     = ALU_ADD;
                        add_const   = 1'b1;
                        SEXT_Select = SX_OFF6;
                        mem_wr_en   = 1'b1;
                    end
                    default: begin
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC2: begin
                if (w_op == OP_STI) begin
                    state2_STI  = 1'b1;
                    RF_r_addr_0 = w_dr;
                    mem_wr_en   = 1'b1;
                    w_next      = S_FETCH;
                end else begin
                    mem_r_addr_sel = MRA_IND;
                    RF_wr_addr     = w_dr;
                    RF_wr_en       = 1'b1;
                    RF_w_data_sel  = WDS_MEM;
                    w_next         = S_CCUPD;
                end
            end
            S_CCUPD: begin
                RF_r_addr_0 = w_dr;
                cc_en       = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: small datapath model, directed programs,
// and a randomized run against a cycle-phase reference model.
module tb_punc_control;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        ir_ld, pc_clr, pc_up, pc_ld, JMP_RET_JSRR;
    logic [2:0]  mem_r_addr_sel;
    logic        mem_wr_en, state2_STI, STR;
    logic [2:0]  RF_r_addr_0, RF_r_addr_1, RF_wr_addr;
    logic        RF_wr_en;
    logic [1:0]  RF_w_data_sel, alu_sel;
    logic        add_const, cc_en, n, z, p;
    logic [10:0] const_n;
    logic [3:0]  SEXT_Select;
    logic        halted;

    int vecs;
    int errs;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir),
        .ir_ld(ir_ld), .pc_clr(pc_clr), .pc_up(pc_up),
        .pc_ld(pc_ld), .JMP_RET_JSRR(JMP_RET_JSRR),
        .mem_r_addr_sel(mem_r_addr_sel), .mem_wr_en(mem_wr_en),
        .state2_STI(state2_STI), .STR(STR),
        .RF_r_addr_0(RF_r_addr_0), .RF_r_addr_1(RF_r_addr_1),
        .RF_wr_addr(RF_wr_addr), .RF_wr_en(RF_wr_en),
        .RF_w_data_sel(RF_w_data_sel), .alu_sel(alu_sel),
        .add_const(add_const), .cc_en(cc_en),
        .n(n), .z(z), .p(p), .const_n(const_n),
        .SEXT_Select(SEXT_Select), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [15:0] mem [0:255];
    logic [15:0] rf  [0:7];
    logic [15:0] pc, ir_q, latch;
    logic [2:0]  nzp;
    logic        tb_clr, tb_rand, tb_we;
    logic [7:0]  tb_a;
    logic [15:0] tb_d;
    logic [15:0] sx, pcsx, a_op, b_op, alu_y, raddr, rdata;
    logic [15:0] wdata, tgt, maddr, mdata;
    logic        take;

    assign ir = ir_q;

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[15:12] == 4'hF && $urandom_range(0, 3) != 0)
            v[15:12] = 4'h1;
        return v;
    endfunction

    always_comb begin
        sx = 16'd0;
        if (SEXT_Select[3])      sx = {{11{ir_q[4]}}, ir_q[4:0]};
        else if (SEXT_Select[2]) sx = {{10{ir_q[5]}}, ir_q[5:0]};
        else if (SEXT_Select[1]) sx = {{7{ir_q[8]}}, ir_q[8:0]};
        else if (SEXT_Select[0]) sx = {{5{ir_q[10]}}, ir_q[10:0]};
        pcsx = pc + sx;
        a_op = rf[RF_r_addr_0];
        b_op = add_const ? sx : rf[RF_r_addr_1];
        case (alu_sel)
            2'd0:    alu_y = a_op;
            2'd1:    alu_y = a_op + b_op;
            2'd2:    alu_y = a_op & b_op;
            default: alu_y = ~a_op;
        endcase
        case (mem_r_addr_sel)
            3'd0:    raddr = pc;
            3'd1:    raddr = pcsx;
            3'd2:    raddr = latch;
            3'd4:    raddr = alu_y;
            default: raddr = 16'd0;
        endcase
        rdata = mem[raddr[7:0]];
        case (RF_w_data_sel)
            2'd0:    wdata = alu_y;
            2'd1:    wdata = pc;
            2'd2:    wdata = rdata;
            default: wdata = pcsx;
        endcase
        take  = (n & nzp[2]) | (z & nzp[1]) | (p & nzp[0]);
        tgt   = JMP_RET_JSRR ? alu_y : pcsx;
        maddr = STR ? alu_y : (state2_STI ? latch : pcsx);
        mdata = STR ? rf[RF_r_addr_1] : alu_y;
    end

    always @(posedge clk) begin
        if (tb_clr || tb_rand) begin
            for (int k = 0; k < 256; k++)
                mem[k] <= tb_rand ? rand_instr() : 16'd0;
            for (int k = 0; k < 8; k++)
                rf[k] <= tb_rand ? 16'($urandom) : 16'd0;
            nzp  <= 3'b000;
            ir_q <= 16'd0;
        end else begin
            if (tb_we) mem[tb_a] <= tb_d;
            if (mem_wr_en) mem[maddr[7:0]] <= mdata;
            if (RF_wr_en) rf[RF_wr_addr] <= wdata;
            if (ir_ld) ir_q <= rdata;
            if (cc_en)
                nzp <= alu_y[15] ? 3'b100 :
                       (alu_y == 16'd0) ? 3'b010 : 3'b001;
        end
        latch <= rdata;
        if (pc_clr)              pc <= 16'd0;
        else if (pc_ld || take)  pc <= tgt;
        else if (pc_up)          pc <= pc + 16'd1;
    end

    // ---------------- reference model ----------------
    // Phase: -1 INIT, 0 fetch, 1 decode, 2.. execute steps, 99 halt.
    function automatic logic [45:0] exp_vec(input logic [15:0] i,
                                            input int ph,
                                            input logic rs);
        logic il, pcc, pu, pl, jr, mw, s2, st, we, ac, cc, hl;
        logic [2:0] mr, r0, r1, wa, msk;
        logic [1:0] wds, alu;
        logic [3:0] sxs, op;
        logic [2:0] dr, sr;
        int e, step;
        {il, pcc, pu, pl, jr, mw, s2, st, we, ac, cc, hl} = '0;
        {mr, r0, r1, wa, msk} = '0;
        {wds, alu, sxs} = '0;
        op = i[15:12];
        dr = i[11:9];
        sr = i[8:6];
        e = rs ? -1 : ph;
        step = e - 2;
        if (e == -1) pcc = 1'b1;
        else if (e == 0) begin il = 1'b1; pu = 1'b1; end
        else if (e == 99) hl = 1'b1;
        else if (e >= 2) begin
            case (op)
                4'd1, 4'd5, 4'd9: begin
                    r0 = sr; r1 = i[2:0]; ac = i[5]; sxs = 4'b1000;
                    alu = (op == 4'd1) ? 2'd1 : (op == 4'd5) ? 2'd2 : 2'd3;
                    wa = dr; we = 1'b1; cc = 1'b1;
                end
                4'd0: begin msk = i[11:9]; sxs = 4'b0010; end
                4'd12: begin r0 = sr; jr = 1'b1; pl = 1'b1; end
                4'd4: begin
                    wa = 3'd7; wds = 2'd1; we = 1'b1; pl = 1'b1;
                    if (i[11]) sxs = 4'b0001;
                    else begin r0 = sr; jr = 1'b1; end
                end
                4'd2, 4'd6, 4'd14: begin
                    if (step == 0) begin
                        wa = dr; we = 1'b1;
                        wds = (op == 4'd14) ? 2'd3 : 2'd2;
                        if (op == 4'd6) begin
                            mr = 3'd4; r0 = sr; alu = 2'd1;
                            ac = 1'b1; sxs = 4'b0100;
                        end else begin
                            sxs = 4'b0010;
                            if (op == 4'd2) mr = 3'd1;
                        end
                    end else begin r0 = dr; cc = 1'b1; end
                end
                4'd10: begin
                    if (step == 0) begin mr = 3'd1; sxs = 4'b0010; end
                    else if (step == 1) begin
                        mr = 3'd2; wa = dr; we = 1'b1; wds = 2'd2;
                    end else begin r0 = dr; cc = 1'b1; end
                end
                4'd11: begin
                    if (step == 0) begin mr = 3'd1; sxs = 4'b0010; end
                    else begin s2 = 1'b1; r0 = dr; mw = 1'b1; end
                end
                4'd3: begin r0 = dr; sxs = 4'b0010; mw = 1'b1; end
                4'd7: begin
                    st = 1'b1; r0 = sr; r1 = dr; alu = 2'd1;
                    ac = 1'b1; sxs = 4'b0100; mw = 1'b1;
                end
                default: ;
            endcase
        end
        return {il, pcc, pu, pl, jr, mr, mw, s2, st, r0, r1, wa, we,
                wds, alu, ac, cc, msk, i[10:0], sxs, hl};
    endfunction

    function automatic int next_ph(input int ph, input logic rs,
                                   input logic [15:0] i);
        int len;
        logic [3:0] op;
        op = i[15:12];
        if (op == 4'd2 || op == 4'd6 || op == 4'd14 || op == 4'd11)
            len = 2;
        else if (op == 4'd10) len = 3;
        else len = 1;
        if (rs) return -1;
        if (ph == -1) return 0;
        if (ph == 0) return 1;
        if (ph == 1) return (op == 4'd15) ? 99 : 2;
        if (ph == 99) return 99;
        return (ph - 1 < len) ? ph + 1 : 0;
    endfunction

    logic [45:0] got;
    assign got = {ir_ld, pc_clr, pc_up, pc_ld, JMP_RET_JSRR,
                  mem_r_addr_sel, mem_wr_en, state2_STI, STR,
                  RF_r_addr_0, RF_r_addr_1, RF_wr_addr, RF_wr_en,
                  RF_w_data_sel, alu_sel, add_const, cc_en,
                  n, z, p, const_n, SEXT_Select, halted};

    // ---------------- stimulus helpers ----------------
    task automatic clear_dp();
        rst = 1'b1;
        @(negedge clk); tb_clr = 1'b1;
        @(negedge clk); tb_clr = 1'b0;
    endtask

    task automatic poke(input logic [7:0] ad, input logic [15:0] d);
        tb_a = ad; tb_d = d; tb_we = 1'b1;
        @(negedge clk); tb_we = 1'b0;
    endtask

    // Releases reset at a negedge; that cycle is INIT (cycle 0).
    task automatic release_rst();
        @(negedge clk); rst = 1'b0; #1;
    endtask

    task automatic step_to(input int cyc);
        repeat (cyc) @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_dp();
        #1;
        vecs++;
        if (got !== exp_vec(ir, -1, 1'b1)) begin
            errs++;
            $display("FAIL reset_decode got=%h exp=%h",
                     got, exp_vec(ir, -1, 1'b1));
        end
        vecs++;
        if (halted !== 1'b0 || RF_wr_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            errs++;
            $display("FAIL reset_enables h=%b rw=%b mw=%b exp 0",
                     halted, RF_wr_en, mem_wr_en);
        end
        release_rst();
        vecs++;
        if (pc_clr !== 1'b1) begin
            errs++; $display("FAIL init_pc_clr got=%b exp=1", pc_clr);
        end
        step_to(1);
        vecs++;
        if (ir_ld !== 1'b1 || pc !== 16'd0) begin
            errs++;
            $display("FAIL first_fetch ir_ld=%b pc=%h exp 1/0000", ir_ld, pc);
        end
    endtask

    task automatic test_add();
        int hit;
        clear_dp();
        poke(8'h00, 16'h1225);
        release_rst();
        hit = -1;
        for (int c = 1; c <= 10 && hit < 0; c++) begin
            step_to(1);
            if (c > 1 && ir_ld === 1'b1) hit = c;
        end
        vecs++;
        if (hit != 4) begin
            errs++; $display("FAIL add_next_fetch got=%0d exp=4", hit);
        end
        vecs++;
        if (rf[1] !== 16'd5 || nzp !== 3'b001) begin
            errs++;
            $display("FAIL add_result r1=%h nzp=%b exp 0005/001", rf[1], nzp);
        end
    endtask

    task automatic test_branch();
        logic [15:0] br [2];
        logic [15:0] want [2];
        br[0] = 16'h0402; want[0] = 16'd4;
        br[1] = 16'h0202; want[1] = 16'd2;
        for (int k = 0; k < 2; k++) begin
            clear_dp();
            poke(8'h00, 16'h5260);
            poke(8'h01, br[k]);
            release_rst();
            step_to(7);
            vecs++;
            if (pc !== want[k] || ir_ld !== 1'b1) begin
                errs++;
                $display("FAIL branch_%0d pc=%h ir_ld=%b exp %h/1",
                         k, pc, ir_ld, want[k]);
            end
        end
    endtask

    task automatic test_ldi();
        logic [5:0] sig [7];
        logic [5:0] cur;
        sig[1] = {1'b1, 3'd0, 1'b0, 1'b0};
        sig[2] = {1'b0, 3'd0, 1'b0, 1'b0};
        sig[3] = {1'b0, 3'd1, 1'b0, 1'b0};
        sig[4] = {1'b0, 3'd2, 1'b1, 1'b0};
        sig[5] = {1'b0, 3'd0, 1'b0, 1'b1};
        sig[6] = {1'b1, 3'd0, 1'b0, 1'b0};
        clear_dp();
        poke(8'h00, 16'hA402);
        poke(8'h03, 16'h0010);
        poke(8'h10, 16'hFFFF);
        release_rst();
        for (int c = 1; c <= 6; c++) begin
            step_to(1);
            cur = {ir_ld, mem_r_addr_sel, RF_wr_en, cc_en};
            vecs++;
            if (cur !== sig[c]) begin
                errs++;
                $display("FAIL ldi_cycle%0d got=%b exp=%b", c, cur, sig[c]);
            end
        end
        vecs++;
        if (rf[2] !== 16'hFFFF || nzp !== 3'b100) begin
            errs++;
            $display("FAIL ldi_result r2=%h nzp=%b exp ffff/100", rf[2], nzp);
        end
    endtask

    task automatic test_jsr_jmp();
        clear_dp();
        poke(8'h00, 16'h4804);
        poke(8'h05, 16'hC1C0);
        release_rst();
        step_to(4);
        vecs++;
        if (pc !== 16'd5 || rf[7] !== 16'd1) begin
            errs++;
            $display("FAIL jsr pc=%h r7=%h exp 0005/0001", pc, rf[7]);
        end
        step_to(3);
        vecs++;
        if (pc !== 16'd1 || ir_ld !== 1'b1) begin
            errs++;
            $display("FAIL jmp pc=%h ir_ld=%b exp 0001/1", pc, ir_ld);
        end
    endtask

    task automatic test_halt();
        clear_dp();
        poke(8'h00, 16'hF025);
        release_rst();
        step_to(2);
        vecs++;
        if (halted !== 1'b0) begin
            errs++; $display("FAIL halt_decode got=%b exp=0", halted);
        end
        step_to(1);
        vecs++;
        if (halted !== 1'b1) begin
            errs++; $display("FAIL halt_entry got=%b exp=1", halted);
        end
        step_to(10);
        vecs++;
        if (halted !== 1'b1 || pc !== 16'd1 || ir_ld !== 1'b0) begin
            errs++;
            $display("FAIL halt_hold h=%b pc=%h ir_ld=%b exp 1/0001/0",
                     halted, pc, ir_ld);
        end
        @(negedge clk); rst = 1'b1; #1;
        vecs++;
        if (halted !== 1'b0 || pc_clr !== 1'b1) begin
            errs++;
            $display("FAIL halt_reset h=%b pc_clr=%b exp 0/1", halted, pc_clr);
        end
    endtask

    task automatic test_sti_reset();
        clear_dp();
        poke(8'h00, 16'hB002);
        poke(8'h03, 16'h0020);
        poke(8'h20, 16'h1234);
        release_rst();
        step_to(4);
        vecs++;
        if (state2_STI !== 1'b1 || mem_wr_en !== 1'b1) begin
            errs++;
            $display("FAIL sti_exec2 s2=%b mw=%b exp 1/1", state2_STI, mem_wr_en);
        end
        rst = 1'b1; #1;
        vecs++;
        if (mem_wr_en !== 1'b0 || pc_clr !== 1'b1) begin
            errs++;
            $display("FAIL sti_rst_decode mw=%b pc_clr=%b exp 0/1",
                     mem_wr_en, pc_clr);
        end
        release_rst();
        vecs++;
        if (mem[8'h20] !== 16'h1234 || pc_clr !== 1'b1) begin
            errs++;
            $display("FAIL sti_no_write m20=%h pc_clr=%b exp 1234/1",
                     mem[8'h20], pc_clr);
        end
        step_to(1);
        vecs++;
        if (ir_ld !== 1'b1 || pc !== 16'd0) begin
            errs++;
            $display("FAIL sti_refetch ir_ld=%b pc=%h exp 1/0000", ir_ld, pc);
        end
    endtask

    task automatic test_random();
        int ph;
        logic [45:0] e;
        rst = 1'b1;
        @(negedge clk); tb_rand = 1'b1;
        @(negedge clk); tb_rand = 1'b0;
        @(posedge clk);
        ph = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            #1;
            e = exp_vec(ir, ph, rst);
            vecs++;
            if (got !== e) begin
                errs++;
                $display("FAIL rand_c%0d ir=%h ph=%0d got=%h exp=%h",
                         c, ir, ph, got, e);
            end
            ph = next_ph(ph, rst, ir);
        end
    endtask

    initial begin
        vecs = 0; errs = 0;
        rst = 1'b1; tb_clr = 1'b0; tb_rand = 1'b0; tb_we = 1'b0;
        tb_a = 8'd0; tb_d = 16'd0;
        pc = 16'd0; latch = 16'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_branch();
        test_ldi();
        test_jsr_jmp();
        test_halt();
        test_sti_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
